// File: rtl/udcount_mc.sv
// udcount_mc: NCH independent WIDTH-bit up/down counters behind one active-low
// chip-select register bus, with per-channel limits and wrap/stop/bounce modes.
module udcount_mc #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHW+1:0]       a,
  input  logic                 ncs,
  input  logic                 nwr,
  input  logic                 nrd,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 err,
  output logic [NCH-1:0]       ec,
  output logic [NCH-1:0]       dir,
  output logic [NCH*WIDTH-1:0] count
);

  localparam int             NSLOT       = 1 << CHW;
  localparam logic [CHW:0]   NCH_L       = (CHW+1)'(NCH);
  localparam logic [1:0]     REG_CTRL    = 2'd0;
  localparam logic [1:0]     REG_LOAD    = 2'd1;
  localparam logic [1:0]     REG_LIMIT   = 2'd2;
  localparam logic [1:0]     REG_COUNT   = 2'd3;
  localparam logic [1:0]     MODE_WRAP   = 2'b00;
  localparam logic [1:0]     MODE_STOP   = 2'b01;
  localparam logic [1:0]     MODE_BOUNCE = 2'b10;
  localparam logic [1:0]     MODE_BAD    = 2'b11;
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r [NCH];
  logic [WIDTH-1:0] load_r  [NCH];
  logic [WIDTH-1:0] limit_r [NCH];
  logic [1:0]       mode_r  [NCH];
  logic [NCH-1:0]   en_r, cdir_r, edir_r, ec_r;
  logic [WIDTH-1:0] dout_r;
  logic             err_r;

  logic [WIDTH-1:0] count_s [NCH];
  logic [WIDTH-1:0] load_s  [NCH];
  logic [WIDTH-1:0] limit_s [NCH];
  logic [1:0]       mode_s  [NCH];
  logic [NCH-1:0]   en_s, cdir_s, edir_s, ec_s;

  logic             wr_s, rd_s, both_s, ch_ok_s, illegal_s, wr_ok_s, rd_ok_s;
  logic [CHW-1:0]   ch_s;
  logic [1:0]       rsel_s;
  logic [WIDTH-1:0] slot_s [NSLOT];
  logic [WIDTH-1:0] rdata_s;

  // Bus strobe decode and illegal-access classification
  always_comb begin
    wr_s      = ~ncs & ~nwr & nrd;
    rd_s      = ~ncs & nwr & ~nrd;
    both_s    = ~ncs & ~nwr & ~nrd;
    ch_s      = a[CHW+1:2];
    rsel_s    = a[1:0];
    ch_ok_s   = ({1'b0, ch_s} < NCH_L);
    illegal_s = both_s
              | ((wr_s | rd_s) & ~ch_ok_s)
              | (wr_s & (rsel_s == REG_COUNT))
              | (wr_s & (rsel_s == REG_CTRL) & (din[3:2] == MODE_BAD));
    wr_ok_s   = wr_s & ~illegal_s;
    rd_ok_s   = rd_s & ~illegal_s;
  end

  // Read-data mux; slots beyond NCH stay zero so an out-of-range index is harmless
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      slot_s[i] = ZERO_W;
    end
    for (int i = 0; i < NCH; i++) begin
      case (rsel_s)
        REG_CTRL:  slot_s[i] = {{(WIDTH-4){1'b0}}, mode_r[i], cdir_r[i], en_r[i]};
        REG_LOAD:  slot_s[i] = load_r[i];
        REG_LIMIT: slot_s[i] = limit_r[i];
        REG_COUNT: slot_s[i] = count_r[i];
        default:   slot_s[i] = ZERO_W;
      endcase
    end
    rdata_s = rd_ok_s ? slot_s[ch_s] : ZERO_W;
  end

  // Per-channel next state: register writes, load command and one counting step
  always_comb begin
    logic             sel_v, ctrl_wr_v, en_v, edir_v, moved_v;
    logic [1:0]       mode_v;
    logic [WIDTH-1:0] term_v, up_v, dn_v;
    for (int i = 0; i < NCH; i++) begin
      sel_v      = wr_ok_s && (ch_s == CHW'(i));
      ctrl_wr_v  = sel_v && (rsel_s == REG_CTRL);
      // A CTRL write is seen by the step of the same edge
      en_v       = ctrl_wr_v ? din[0]   : en_r[i];
      edir_v     = ctrl_wr_v ? din[1]   : edir_r[i];
      mode_v     = ctrl_wr_v ? din[3:2] : mode_r[i];
      en_s[i]    = en_v;
      mode_s[i]  = mode_v;
      cdir_s[i]  = ctrl_wr_v ? din[1] : cdir_r[i];
      load_s[i]  = (sel_v && (rsel_s == REG_LOAD))  ? din : load_r[i];
      limit_s[i] = (sel_v && (rsel_s == REG_LIMIT)) ? din : limit_r[i];
      term_v     = edir_v ? limit_r[i] : ZERO_W;
      up_v       = count_r[i] + ONE_W;
      dn_v       = count_r[i] - ONE_W;
      count_s[i] = count_r[i];
      edir_s[i]  = edir_v;
      moved_v    = 1'b0;
      if (ctrl_wr_v && din[4]) begin
        count_s[i] = load_r[i];
      end else if (start && en_v) begin
        moved_v = 1'b1;
        case (mode_v)
          MODE_WRAP: begin
            if (count_r[i] == term_v) begin
              count_s[i] = edir_v ? ZERO_W : limit_r[i];
            end else begin
              count_s[i] = edir_v ? up_v : dn_v;
            end
          end
          MODE_STOP: begin
            if (count_r[i] == term_v) begin
              count_s[i] = count_r[i];
              moved_v    = 1'b0;
            end else begin
              count_s[i] = edir_v ? up_v : dn_v;
            end
          end
          MODE_BOUNCE: begin
            // Sitting on the terminal without having stepped onto it: turn around now
            if (count_r[i] == term_v) begin
              count_s[i] = edir_v ? dn_v : up_v;
              edir_s[i]  = ~edir_v;
              moved_v    = 1'b0;
            end else begin
              count_s[i] = edir_v ? up_v : dn_v;
              edir_s[i]  = ((edir_v ? up_v : dn_v) == term_v) ? ~edir_v : edir_v;
            end
          end
          default: begin
            count_s[i] = count_r[i];
            moved_v    = 1'b0;
          end
        endcase
      end else begin
        count_s[i] = count_r[i];
      end
      ec_s[i] = moved_v && (count_s[i] == term_v);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        count_r[i] <= ZERO_W;
        load_r[i]  <= ZERO_W;
        limit_r[i] <= ONES_W;
        mode_r[i]  <= MODE_WRAP;
      end
      en_r   <= {NCH{1'b0}};
      cdir_r <= {NCH{1'b0}};
      edir_r <= {NCH{1'b0}};
      ec_r   <= {NCH{1'b0}};
      dout_r <= ZERO_W;
      err_r  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        count_r[i] <= count_s[i];
        load_r[i]  <= load_s[i];
        limit_r[i] <= limit_s[i];
        mode_r[i]  <= mode_s[i];
      end
      en_r   <= en_s;
      cdir_r <= cdir_s;
      edir_r <= edir_s;
      ec_r   <= ec_s;
      dout_r <= rdata_s;
      err_r  <= illegal_s;
    end
  end

  assign dout = dout_r;
  assign err  = err_r;
  assign ec   = ec_r;
  assign dir  = edir_r;

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign count[g*WIDTH +: WIDTH] = count_r[g];
  end

endmodule
